pc_unit: RTL and testbench



---
 rtl/mycpu_pkg.sv | 15 +
 rtl/pc_next_mux.sv | 26 ++
 rtl/pc_unit.sv | 54 +++++
 tb/tb_pc_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared mycpu types and constants: PC select codes, PC width, reset vector, bench clock period.
package mycpu_pkg;

  localparam int unsigned PC_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 16'h0000;
  localparam int unsigned CLK_PERIOD = 10;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_IA   = 2'b10,
    PC_RA   = 2'b11
  } pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: hold, increment (wrapping), immediate target or register target.
module pc_next_mux
  import mycpu_pkg::*;
#(
  parameter int unsigned W = mycpu_pkg::PC_WIDTH
) (
  input  logic [W-1:0] pc_i,
  input  pc_sel_t      ps_in,
  input  logic [W-1:0] ia_in,
  input  logic [W-1:0] ra_in,
  output logic [W-1:0] next_pc_o
);

  // Unknown select codes fall through to default and hold the PC.
  always_comb begin
    next_pc_o = pc_i;
    case (ps_in)
      PC_HOLD: next_pc_o = pc_i;
      PC_INC:  next_pc_o = pc_i + W'(1);
      PC_IA:   next_pc_o = ia_in;
      PC_RA:   next_pc_o = ra_in;
      default: next_pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// mycpu program counter register with synchronous active-high reset.
// Optional embedded SVA/coverage when MYCPU_PC_ASSERT_EN is defined (simulation only).
module pc_unit #(
  parameter int unsigned             PC_WIDTH     = mycpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = mycpu_pkg::PC_RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  mycpu_pkg::pc_sel_t    ps_in,
  input  logic [PC_WIDTH-1:0]   ia_in,
  input  logic [PC_WIDTH-1:0]   ra_in,
  output logic [PC_WIDTH-1:0]   pc_out
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  pc_next_mux #(
    .W(PC_WIDTH)
  ) u_next_mux (
    .pc_i      (pc_q),
    .ps_in     (ps_in),
    .ia_in     (ia_in),
    .ra_in     (ra_in),
    .next_pc_o (pc_d)
  );

  // Reset wins over any in-flight select.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

  assign pc_out = pc_q;

`ifdef MYCPU_PC_ASSERT_EN
`ifndef SYNTHESIS
  a_sel_known: assert property (@(posedge clk) !rst |-> !$isunknown(ps_in));
  a_hold:  assert property (@(posedge clk) (!rst && ps_in == mycpu_pkg::PC_HOLD) |=> pc_out == $past(pc_out));
  a_inc:   assert property (@(posedge clk) (!rst && ps_in == mycpu_pkg::PC_INC)  |=> pc_out == $past(pc_out) + PC_WIDTH'(1));
  a_ia:    assert property (@(posedge clk) (!rst && ps_in == mycpu_pkg::PC_IA)   |=> pc_out == $past(ia_in));
  a_ra:    assert property (@(posedge clk) (!rst && ps_in == mycpu_pkg::PC_RA)   |=> pc_out == $past(ra_in));
  a_reset: assert property (@(posedge clk) rst |=> pc_out == RESET_VECTOR);

  c_hold:  cover property (@(posedge clk) !rst && ps_in == mycpu_pkg::PC_HOLD);
  c_inc:   cover property (@(posedge clk) !rst && ps_in == mycpu_pkg::PC_INC);
  c_ia:    cover property (@(posedge clk) !rst && ps_in == mycpu_pkg::PC_IA);
  c_ra:    cover property (@(posedge clk) !rst && ps_in == mycpu_pkg::PC_RA);
  c_wrap:  cover property (@(posedge clk) !rst && ps_in == mycpu_pkg::PC_INC && pc_out == '1);
  c_rst_busy: cover property (@(posedge clk) rst && ps_in != mycpu_pkg::PC_HOLD);
`endif
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized run against an arithmetic reference model.
module tb_pc_unit;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  pc_sel_t     ps_in;
  logic [15:0] ia_in;
  logic [15:0] ra_in;
  logic [15:0] pc_out;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_pc  = 0;
  int sel_seen [4];

  pc_unit dut (
    .clk    (clk),
    .rst    (rst),
    .ps_in  (ps_in),
    .ia_in  (ia_in),
    .ra_in  (ra_in),
    .pc_out (pc_out)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: next PC from the selection rules using plain integer arithmetic.
  function automatic int model_next(input int pc, input bit r, input int sel, input int ia, input int ra);
    if (r) return 0;
    case (sel)
      1:       return (pc + 1) % 65536;
      2:       return ia;
      3:       return ra;
      default: return pc;
    endcase
  endfunction

  // Drive one cycle's inputs, clock it, then check pc_out against the model.
  task automatic cycle(input string tag, input bit r, input int sel, input int ia, input int ra);
    rst   = r;
    ps_in = pc_sel_t'(2'(sel));
    ia_in = 16'(ia);
    ra_in = 16'(ra);
    @(posedge clk);
    #1;
    exp_pc = model_next(exp_pc, r, sel, ia, ra);
    check(tag, 32'(pc_out), 32'(exp_pc));
  endtask

  initial begin
    rst = 1'b1; ps_in = PC_INC; ia_in = '0; ra_in = '0;
    @(negedge clk);

    cycle("reset0", 1, 1, 0, 0);
    check("reset_val", 32'(pc_out), 32'h0000);
    cycle("reset1", 1, 1, 16'h5555, 16'hAAAA);
    for (int i = 1; i <= 3; i++) begin
      cycle("inc_after_rst", 0, 1, 0, 0);
      check("inc_abs", 32'(pc_out), 32'(i));
    end
    cycle("inc4", 0, 1, 0, 0);
    cycle("inc5", 0, 1, 0, 0);
    check("at5", 32'(pc_out), 32'h0005);

    for (int i = 0; i < 4; i++) begin
      cycle("hold", 0, 0, (i % 2 == 0) ? 16'hFFFF : 16'h0000, (i % 2 == 0) ? 16'h0000 : 16'hFFFF);
      check("hold_abs", 32'(pc_out), 32'h0005);
    end

    cycle("jump_ia", 0, 2, 16'h1234, 16'h9999);
    check("jump_ia_abs", 32'(pc_out), 32'h1234);
    cycle("jump_ra", 0, 3, 16'h7777, 16'hBEEF);
    check("jump_ra_abs", 32'(pc_out), 32'hBEEF);
    cycle("inc_beef", 0, 1, 0, 0);
    check("inc_beef_abs", 32'(pc_out), 32'hBEF0);

    cycle("ia_ffff", 0, 2, 16'hFFFF, 0);
    cycle("wrap", 0, 1, 0, 0);
    check("wrap_abs", 32'(pc_out), 32'h0000);

    cycle("ia_a0", 0, 2, 16'h00A0, 0);
    check("ia_a0_abs", 32'(pc_out), 32'h00A0);
    cycle("mid_rst", 1, 2, 16'h4000, 0);
    check("mid_rst_abs", 32'(pc_out), 32'h0000);
    cycle("post_rst", 0, 1, 0, 0);
    check("post_rst_abs", 32'(pc_out), 32'h0001);

    for (int i = 0; i < 1000; i++) begin
      int sel;
      bit r;
      sel = int'($urandom_range(0, 3));
      r   = ($urandom_range(0, 31) == 0);
      if (!r) sel_seen[sel]++;
      cycle("random", r, sel, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end
    for (int s = 0; s < 4; s++)
      check("sel_covered", 32'(sel_seen[s] > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
